// File: rtl/f_table_server.sv
// F/B table responder for the formant DP engine: 2-cycle pipelined F(k-1,j) reads,
// writes accepted at any time, and a traceback FSM that walks B from (K, i_end) down to k=1.
module f_table_server #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int FORMANTS  = 5
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             req_valid,
  input  logic [$clog2(FORMANTS+1)-1:0]    k_req,
  input  logic signed [$clog2(I):0]        j_req,
  output logic [BIT_WIDTH-1:0]             f_prev,
  output logic                             f_prev_valid,
  input  logic                             wr_valid,
  input  logic [$clog2(FORMANTS+1)-1:0]    k_write,
  input  logic [$clog2(I)-1:0]             i_write,
  input  logic [BIT_WIDTH-1:0]             f_data,
  input  logic [BIT_WIDTH-1:0]             b_data,
  input  logic                             tb_start,
  input  logic [$clog2(I)-1:0]             tb_i_end,
  input  logic [$clog2(FORMANTS+1)-1:0]    tb_k,
  output logic                             tb_busy,
  output logic [BIT_WIDTH-1:0]             boundary_out,
  output logic                             boundary_valid,
  output logic                             tb_done
);

  localparam int KW = $clog2(FORMANTS+1);
  localparam int IW = $clog2(I);
  localparam int N  = FORMANTS * I;
  localparam int AW = $clog2(N);
  localparam logic [BIT_WIDTH-1:0] INF = BIT_WIDTH'(32'h3FFF_FFFF);

  typedef enum logic [2:0] {IDLE, RD, WT, EMIT, DONE} state_t;

  logic [BIT_WIDTH-1:0] f_mem [0:N-1];
  logic [BIT_WIDTH-1:0] b_mem [0:N-1];
  logic [N-1:0]         flags;

  logic          wr_ok, rd_zero, rd_hit, rd_go, tb_ok;
  logic [AW-1:0] wr_addr, rd_addr, tb_addr;

  logic [BIT_WIDTH-1:0] f_rd, b_rd;
  logic                 s1_vld, s1_zero, s1_hit, s1_flag, tb_flag;

  state_t               state;
  logic [KW-1:0]        tb_kq;
  logic [BIT_WIDTH-1:0] tb_iq;

  always_comb begin
    wr_ok   = wr_valid && (k_write >= KW'(1)) && (k_write <= KW'(FORMANTS)) &&
              ({1'b0, i_write} < (IW+1)'(I));
    wr_addr = wr_ok ? AW'((int'(k_write) - 1) * I + int'(i_write)) : '0;

    // Entry served is k_req-1, so only k_req in 2..FORMANTS+1 touches storage
    rd_go   = req_valid && !tb_busy;
    rd_zero = (k_req == KW'(1)) && (j_req == '1);
    rd_hit  = (k_req >= KW'(2)) && (int'(k_req) <= FORMANTS + 1) && !j_req[IW] &&
              ({1'b0, j_req[IW-1:0]} < (IW+1)'(I));
    rd_addr = rd_hit ? AW'((int'(k_req) - 2) * I + int'(j_req[IW-1:0])) : '0;

    tb_ok   = tb_iq < BIT_WIDTH'(I);
    tb_addr = tb_ok ? AW'((int'(tb_kq) - 1) * I + int'(tb_iq[IW-1:0])) : '0;
  end

  // Non-blocking reads alongside the write give read-first behaviour on collisions
  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      f_mem[wr_addr] <= f_data;
      b_mem[wr_addr] <= b_data;
    end
    f_rd <= f_mem[rd_addr];
    b_rd <= b_mem[tb_addr];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      flags        <= '0;
      s1_vld       <= 1'b0;
      s1_zero      <= 1'b0;
      s1_hit       <= 1'b0;
      s1_flag      <= 1'b0;
      tb_flag      <= 1'b0;
      f_prev       <= '0;
      f_prev_valid <= 1'b0;
    end else begin
      if (wr_ok) flags[wr_addr] <= 1'b1;
      s1_vld       <= rd_go;
      s1_zero      <= rd_zero;
      s1_hit       <= rd_hit;
      s1_flag      <= rd_hit && flags[rd_addr];
      tb_flag      <= tb_ok && flags[tb_addr];
      f_prev_valid <= s1_vld;
      if (s1_vld)
        f_prev <= s1_zero ? '0 : (s1_hit && s1_flag) ? f_rd : INF;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      tb_busy        <= 1'b0;
      tb_done        <= 1'b0;
      boundary_out   <= '0;
      boundary_valid <= 1'b0;
      tb_kq          <= '0;
      tb_iq          <= '0;
    end else begin
      boundary_valid <= 1'b0;
      tb_done        <= 1'b0;
      case (state)
        IDLE: if (tb_start) begin
          if (tb_k >= KW'(1) && tb_k <= KW'(FORMANTS)) begin
            tb_kq   <= tb_k;
            tb_iq   <= BIT_WIDTH'(tb_i_end);
            tb_busy <= 1'b1;
            state   <= RD;
          end else begin
            tb_done <= 1'b1;
            state   <= DONE;
          end
        end
        RD: state <= WT;
        WT: begin
          boundary_out   <= tb_flag ? b_rd : '1;
          boundary_valid <= 1'b1;
          state          <= EMIT;
        end
        EMIT: begin
          if (tb_kq == KW'(1) || boundary_out[BIT_WIDTH-1]) begin
            tb_busy <= 1'b0;
            tb_done <= 1'b1;
            state   <= DONE;
          end else begin
            tb_kq <= tb_kq - KW'(1);
            tb_iq <= boundary_out;
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f_table_server.sv
// Directed bench for f_table_server: read latency/values, read-first collision,
// traceback ordering and spacing, busy gating, and mid-traceback reset.
module tb_f_table_server;

  localparam logic [31:0] INF = 32'h3FFF_FFFF;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              req_valid;
  logic [2:0]        k_req;
  logic signed [8:0] j_req;
  logic [31:0]       f_prev;
  logic              f_prev_valid;
  logic              wr_valid;
  logic [2:0]        k_write;
  logic [7:0]        i_write;
  logic [31:0]       f_data;
  logic [31:0]       b_data;
  logic              tb_start;
  logic [7:0]        tb_i_end;
  logic [2:0]        tb_k;
  logic              tb_busy;
  logic [31:0]       boundary_out;
  logic              boundary_valid;
  logic              tb_done;

  int errors = 0;
  int checks = 0;
  int seen_done;
  int seen_bv;

  f_table_server dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid(req_valid), .k_req(k_req), .j_req(j_req),
    .f_prev(f_prev), .f_prev_valid(f_prev_valid),
    .wr_valid(wr_valid), .k_write(k_write), .i_write(i_write),
    .f_data(f_data), .b_data(b_data),
    .tb_start(tb_start), .tb_i_end(tb_i_end), .tb_k(tb_k),
    .tb_busy(tb_busy), .boundary_out(boundary_out),
    .boundary_valid(boundary_valid), .tb_done(tb_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] k, input logic [7:0] i, input logic [31:0] f, input logic [31:0] b);
    wr_valid = 1'b1; k_write = k; i_write = i; f_data = f; b_data = b;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; req_valid = 1'b0; k_req = '0; j_req = '0;
    wr_valid = 1'b0; k_write = '0; i_write = '0; f_data = '0; b_data = '0;
    tb_start = 1'b0; tb_i_end = '0; tb_k = '0;
    step(); step();
    rst_n_in = 1'b1;
    chk("rst_f_prev", f_prev, 32'd0);
    chk("rst_f_prev_valid", {31'd0, f_prev_valid}, 32'd0);
    chk("rst_tb_busy", {31'd0, tb_busy}, 32'd0);
    chk("rst_boundary_out", boundary_out, 32'd0);
    chk("rst_boundary_valid", {31'd0, boundary_valid}, 32'd0);
    chk("rst_tb_done", {31'd0, tb_done}, 32'd0);

    // 1: write then read with 2-cycle latency
    wr(3'd1, 8'd5, 32'd100, 32'd0);
    req_valid = 1'b1; k_req = 3'd2; j_req = 9'sd5;
    step();
    req_valid = 1'b0;
    chk("t1_valid_t1", {31'd0, f_prev_valid}, 32'd0);
    step();
    chk("t1_valid_t2", {31'd0, f_prev_valid}, 32'd1);
    chk("t1_data", f_prev, 32'd100);
    step();
    chk("t1_valid_t3", {31'd0, f_prev_valid}, 32'd0);

    // 2: four back-to-back special-case reads
    req_valid = 1'b1; k_req = 3'd1; j_req = -9'sd1;
    step();
    k_req = 3'd1; j_req = 9'sd3;
    step();
    chk("t2_v0", {31'd0, f_prev_valid}, 32'd1);
    chk("t2_base", f_prev, 32'd0);
    k_req = 3'd3; j_req = -9'sd1;
    step();
    chk("t2_v1", {31'd0, f_prev_valid}, 32'd1);
    chk("t2_k1_j3", f_prev, INF);
    k_req = 3'd2; j_req = 9'sd7;
    step();
    chk("t2_v2", {31'd0, f_prev_valid}, 32'd1);
    chk("t2_k3_jneg", f_prev, INF);
    req_valid = 1'b0;
    step();
    chk("t2_v3", {31'd0, f_prev_valid}, 32'd1);
    chk("t2_unwritten", f_prev, INF);
    step();
    chk("t2_idle", {31'd0, f_prev_valid}, 32'd0);

    // 3: same-cycle write/read is read-first
    wr_valid = 1'b1; k_write = 3'd2; i_write = 8'd9; f_data = 32'd777; b_data = 32'd0;
    req_valid = 1'b1; k_req = 3'd3; j_req = 9'sd9;
    step();
    wr_valid = 1'b0;
    step();
    req_valid = 1'b0;
    chk("t3_old", f_prev, INF);
    step();
    chk("t3_new_valid", {31'd0, f_prev_valid}, 32'd1);
    chk("t3_new", f_prev, 32'd777);

    // 4: traceback 12, 4, -1 at 3-cycle spacing, then done
    wr(3'd3, 8'd20, 32'd1, 32'd12);
    wr(3'd2, 8'd12, 32'd2, 32'd4);
    wr(3'd1, 8'd4, 32'd3, 32'hFFFF_FFFF);
    tb_start = 1'b1; tb_k = 3'd3; tb_i_end = 8'd20;
    step();
    tb_start = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      chk($sformatf("t4_bv_n%0d", n), {31'd0, boundary_valid}, {31'd0, (n == 2 || n == 5 || n == 8)});
      chk($sformatf("t4_done_n%0d", n), {31'd0, tb_done}, {31'd0, (n == 9)});
      chk($sformatf("t4_busy_n%0d", n), {31'd0, tb_busy}, {31'd0, (n < 9)});
      if (n == 2) chk("t4_b0", boundary_out, 32'd12);
      if (n == 5) chk("t4_b1", boundary_out, 32'd4);
      if (n == 8) chk("t4_b2", boundary_out, 32'hFFFF_FFFF);
      step();
    end

    // tb_k = 0: done pulse only
    tb_start = 1'b1; tb_k = 3'd0;
    step();
    tb_start = 1'b0;
    chk("k0_done", {31'd0, tb_done}, 32'd1);
    chk("k0_bv", {31'd0, boundary_valid}, 32'd0);
    step();
    chk("k0_done_clr", {31'd0, tb_done}, 32'd0);

    // 5: requests ignored while busy, writes still land
    tb_start = 1'b1; tb_k = 3'd3; tb_i_end = 8'd20;
    step();
    tb_start = 1'b0;
    req_valid = 1'b1; k_req = 3'd2; j_req = 9'sd6;
    wr_valid = 1'b1; k_write = 3'd1; i_write = 8'd6; f_data = 32'd555; b_data = 32'd0;
    for (int n = 1; n <= 10; n++) begin
      step();
      wr_valid = 1'b0;
      if (n == 8) req_valid = 1'b0;
      chk($sformatf("t5_novalid_n%0d", n), {31'd0, f_prev_valid}, 32'd0);
      chk($sformatf("t5_done_n%0d", n), {31'd0, tb_done}, {31'd0, (n == 9)});
    end
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("t5_rb_valid", {31'd0, f_prev_valid}, 32'd1);
    chk("t5_rb_data", f_prev, 32'd555);

    // 6: reset during the second EMIT
    tb_start = 1'b1; tb_k = 3'd3; tb_i_end = 8'd20;
    step();
    tb_start = 1'b0;
    for (int n = 1; n <= 5; n++) step();
    chk("t6_bv_pre", {31'd0, boundary_valid}, 32'd1);
    chk("t6_b_pre", boundary_out, 32'd4);
    rst_n_in = 1'b0;
    #1;
    chk("t6_rst_bv", {31'd0, boundary_valid}, 32'd0);
    chk("t6_rst_bout", boundary_out, 32'd0);
    chk("t6_rst_busy", {31'd0, tb_busy}, 32'd0);
    chk("t6_rst_done", {31'd0, tb_done}, 32'd0);
    step(); step();
    rst_n_in = 1'b1;
    seen_done = 0;
    seen_bv = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      seen_done += int'(tb_done);
      seen_bv += int'(boundary_valid);
    end
    chk("t6_no_done", seen_done, 32'd0);
    chk("t6_no_bv", seen_bv, 32'd0);
    req_valid = 1'b1; k_req = 3'd2; j_req = 9'sd5;
    step();
    k_req = 3'd3; j_req = 9'sd9;
    step();
    req_valid = 1'b0;
    chk("t6_rd0_valid", {31'd0, f_prev_valid}, 32'd1);
    chk("t6_rd0", f_prev, INF);
    step();
    chk("t6_rd1_valid", {31'd0, f_prev_valid}, 32'd1);
    chk("t6_rd1", f_prev, INF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
